// File: rtl/pipeline_stage_hs.sv
// pipeline_stage_hs: one pipeline stage register with valid/ready handshake,
// synchronous flush and a saturating downstream-stall counter.
// Build option: define PIPE_STAGE_SKID_EN for the two-entry skid variant
// (registered in_ready); leave it undefined for a single-register stage
// with combinational in_ready.
module pipeline_stage_hs #(
    parameter int DATA_W = 71,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_count
);

    logic it;
    logic ot;
    logic [CNT_W-1:0] stall_cnt_q;

    assign it = in_valid && in_ready;
    assign ot = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN

    typedef enum logic [1:0] {S_EMPTY = 2'd0, S_FULL = 2'd1, S_SKID = 2'd2} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q;

    // State and payload registers; in_ready is precomputed from the next
    // state so it never depends combinationally on out_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != S_SKID);
        end
    end

    // Next-state / payload steering; flush wins and drops any same-cycle beat.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (it) begin
                        state_d = S_FULL;
                        main_d  = in_data;
                    end
                end
                S_FULL: begin
                    if (it && ot) begin
                        main_d = in_data;
                    end else if (it) begin
                        state_d = S_SKID;
                        skid_d  = in_data;
                    end else if (ot) begin
                        state_d = S_EMPTY;
                    end
                end
                S_SKID: begin
                    if (ot) begin
                        state_d = S_FULL;
                        main_d  = skid_q;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // Outputs are straight flop decodes.
    always_comb begin
        out_valid = (state_q != S_EMPTY);
        in_ready  = in_ready_q;
        out_data  = main_q;
    end

`else

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;

    // State and payload registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    // Next-state / payload steering; flush wins and drops any same-cycle beat.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (it) begin
                        state_d = S_FULL;
                        main_d  = in_data;
                    end
                end
                S_FULL: begin
                    if (it) begin
                        main_d = in_data;
                    end else if (ot) begin
                        state_d = S_EMPTY;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // A full stage can take a new beat in the same cycle its beat leaves.
    always_comb begin
        out_valid = (state_q == S_FULL);
        in_ready  = !out_valid || out_ready;
        out_data  = main_q;
    end

`endif

    // Saturating count of cycles where a held beat is refused downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_count = stall_cnt_q;

endmodule
